sync_vg_prog: RTL

SYNC_VG_PROG -- requirements
Module: sync_vg_prog

---
 rtl/sync_vg_prog.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sync_vg_prog.sv
// Programmable video sync generator with shadowed timing.
// Ports: clk/rst, enable, cfg_load + cfg_* timing in; hs/vs/de, x/y, frame/line_start, cfg_pending/cfg_err/running out.
module sync_vg_prog #(
    parameter int X_BITS      = 12,
    parameter int Y_BITS      = 12,
    parameter int DEF_H_TOTAL = 1650,
    parameter int DEF_H_SYNC  = 40,
    parameter int DEF_H_BP    = 220,
    parameter int DEF_H_ACT   = 1280,
    parameter int DEF_V_TOTAL = 750,
    parameter int DEF_V_SYNC  = 5,
    parameter int DEF_V_BP    = 20,
    parameter int DEF_V_ACT   = 720
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_load,
    input  logic [X_BITS-1:0] cfg_h_total,
    input  logic [X_BITS-1:0] cfg_h_sync,
    input  logic [X_BITS-1:0] cfg_h_bp,
    input  logic [X_BITS-1:0] cfg_h_act,
    input  logic [Y_BITS-1:0] cfg_v_total,
    input  logic [Y_BITS-1:0] cfg_v_sync,
    input  logic [Y_BITS-1:0] cfg_v_bp,
    input  logic [Y_BITS-1:0] cfg_v_act,
    input  logic              cfg_hs_pol,
    input  logic              cfg_vs_pol,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic [X_BITS-1:0] x_out,
    output logic [Y_BITS-1:0] y_out,
    output logic              frame_start,
    output logic              line_start,
    output logic              cfg_pending,
    output logic              cfg_err,
    output logic              running
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

    state_t r_state, w_state_nxt;

    logic [X_BITS-1:0] r_h_cnt, w_h_nxt;
    logic [Y_BITS-1:0] r_v_cnt, w_v_nxt;

    // active set drives counting; staging set waits for a frame boundary
    logic [X_BITS-1:0] r_a_h_total, r_a_h_sync, r_a_h_bp, r_a_h_act;
    logic [Y_BITS-1:0] r_a_v_total, r_a_v_sync, r_a_v_bp, r_a_v_act;
    logic              r_a_hs_pol, r_a_vs_pol;
    logic [X_BITS-1:0] r_s_h_total, r_s_h_sync, r_s_h_bp, r_s_h_act;
    logic [Y_BITS-1:0] r_s_v_total, r_s_v_sync, r_s_v_bp, r_s_v_act;
    logic              r_s_hs_pol, r_s_vs_pol;
    logic              r_pending, r_err;

    logic              w_run, w_h_last, w_v_last, w_eof, w_commit;
    logic              w_cfg_ok, w_h_de, w_v_de, w_de;
    logic [X_BITS+1:0] w_cfg_h_sum;
    logic [Y_BITS+1:0] w_cfg_v_sum;
    logic [X_BITS:0]   w_h_start;
    logic [Y_BITS:0]   w_v_start;
    logic [X_BITS+1:0] w_h_end;
    logic [Y_BITS+1:0] w_v_end;

    assign w_run    = (r_state != S_IDLE);
    assign w_h_last = (r_h_cnt == r_a_h_total - X_BITS'(1));
    assign w_v_last = (r_v_cnt == r_a_v_total - Y_BITS'(1));
    assign w_eof    = w_h_last && w_v_last;
    assign w_commit = r_pending && (!w_run || w_eof);

    // sums widened so large fields cannot wrap past the total
    assign w_cfg_h_sum = {2'b0, cfg_h_sync} + {2'b0, cfg_h_bp}
                       + {2'b0, cfg_h_act};
    assign w_cfg_v_sum = {2'b0, cfg_v_sync} + {2'b0, cfg_v_bp}
                       + {2'b0, cfg_v_act};
    assign w_cfg_ok = (|cfg_h_total) && (|cfg_h_sync) && (|cfg_h_act)
                   && (|cfg_v_total) && (|cfg_v_sync) && (|cfg_v_act)
                   && (w_cfg_h_sum <= {2'b0, cfg_h_total})
                   && (w_cfg_v_sum <= {2'b0, cfg_v_total});

    assign w_h_start = {1'b0, r_a_h_sync} + {1'b0, r_a_h_bp};
    assign w_v_start = {1'b0, r_a_v_sync} + {1'b0, r_a_v_bp};
    assign w_h_end   = {1'b0, w_h_start} + {2'b0, r_a_h_act};
    assign w_v_end   = {1'b0, w_v_start} + {2'b0, r_a_v_act};
    assign w_h_de = ({1'b0, r_h_cnt} >= w_h_start)
                 && ({2'b0, r_h_cnt} < w_h_end);
    assign w_v_de = ({1'b0, r_v_cnt} >= w_v_start)
                 && ({2'b0, r_v_cnt} < w_v_end);
    assign w_de   = w_run && w_h_de && w_v_de;

    assign running     = w_run;
    assign cfg_pending = r_pending;
    assign cfg_err     = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h_cnt;
        w_v_nxt     = r_v_cnt;
        unique case (r_state)
            S_IDLE:  if (enable) w_state_nxt = S_RUN;
            S_RUN:   if (!enable) w_state_nxt = S_STOP;
            S_STOP:  if (enable) w_state_nxt = S_RUN;
                     else if (w_eof) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (!w_run) begin
            w_h_nxt = '0;
            w_v_nxt = '0;
        end else if (w_h_last) begin
            w_h_nxt = '0;
            w_v_nxt = w_v_last ? '0 : r_v_cnt + Y_BITS'(1);
        end else begin
            w_h_nxt = r_h_cnt + X_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_a_h_total <= X_BITS'(DEF_H_TOTAL);
            r_a_h_sync  <= X_BITS'(DEF_H_SYNC);
            r_a_h_bp    <= X_BITS'(DEF_H_BP);
            r_a_h_act   <= X_BITS'(DEF_H_ACT);
            r_a_v_total <= Y_BITS'(DEF_V_TOTAL);
            r_a_v_sync  <= Y_BITS'(DEF_V_SYNC);
            r_a_v_bp    <= Y_BITS'(DEF_V_BP);
            r_a_v_act   <= Y_BITS'(DEF_V_ACT);
            r_a_hs_pol  <= 1'b1;
            r_a_vs_pol  <= 1'b1;
            r_s_h_total <= X_BITS'(DEF_H_TOTAL);
            r_s_h_sync  <= X_BITS'(DEF_H_SYNC);
            r_s_h_bp    <= X_BITS'(DEF_H_BP);
            r_s_h_act   <= X_BITS'(DEF_H_ACT);
            r_s_v_total <= Y_BITS'(DEF_V_TOTAL);
            r_s_v_sync  <= Y_BITS'(DEF_V_SYNC);
            r_s_v_bp    <= Y_BITS'(DEF_V_BP);
            r_s_v_act   <= Y_BITS'(DEF_V_ACT);
            r_s_hs_pol  <= 1'b1;
            r_s_vs_pol  <= 1'b1;
            r_pending   <= 1'b0;
            r_err       <= 1'b0;
            hs_out      <= 1'b0;
            vs_out      <= 1'b0;
            de_out      <= 1'b0;
            x_out       <= '0;
            y_out       <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
            if (w_commit) begin
                r_a_h_total <= r_s_h_total;
                r_a_h_sync  <= r_s_h_sync;
                r_a_h_bp    <= r_s_h_bp;
                r_a_h_act   <= r_s_h_act;
                r_a_v_total <= r_s_v_total;
                r_a_v_sync  <= r_s_v_sync;
                r_a_v_bp    <= r_s_v_bp;
                r_a_v_act   <= r_s_v_act;
                r_a_hs_pol  <= r_s_hs_pol;
                r_a_vs_pol  <= r_s_vs_pol;
            end
            // a load accepted in the commit cycle stays pending
            if (cfg_load && w_cfg_ok) begin
                r_s_h_total <= cfg_h_total;
                r_s_h_sync  <= cfg_h_sync;
                r_s_h_bp    <= cfg_h_bp;
                r_s_h_act   <= cfg_h_act;
                r_s_v_total <= cfg_v_total;
                r_s_v_sync  <= cfg_v_sync;
                r_s_v_bp    <= cfg_v_bp;
                r_s_v_act   <= cfg_v_act;
                r_s_hs_pol  <= cfg_hs_pol;
                r_s_vs_pol  <= cfg_vs_pol;
                r_pending   <= 1'b1;
            end else if (w_commit) begin
                r_pending   <= 1'b0;
            end
            if (cfg_load) r_err <= !w_cfg_ok;
            // XNOR with polarity: sync forced inactive while idle
            hs_out      <= (w_run && (r_h_cnt < r_a_h_sync)) ~^ r_a_hs_pol;
            vs_out      <= (w_run && (r_v_cnt < r_a_v_sync)) ~^ r_a_vs_pol;
            de_out      <= w_de;
            x_out       <= w_de ? r_h_cnt - w_h_start[X_BITS-1:0] : '0;
            y_out       <= w_de ? r_v_cnt - w_v_start[Y_BITS-1:0] : '0;
            frame_start <= w_run && (r_h_cnt == '0) && (r_v_cnt == '0);
            line_start  <= w_run && (r_h_cnt == '0);
        end
    end

endmodule
